reg_hazard_ctrl: RTL and testbench



---
 rtl/reg_hazard_ctrl_pkg.sv | 18 +
 rtl/hazard_fwd_mux_sel.sv | 19 +
 rtl/reg_hazard_ctrl.sv | 91 +++++++++
 tb/tb_reg_hazard_ctrl.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/reg_hazard_ctrl_pkg.sv
// Shared definitions for the decode-stage hazard controller: forwarding select
// encodings and the in-flight destination tracker entry.
package reg_hazard_ctrl_pkg;

  localparam int REG_ADDR_W = 5;

  localparam logic [1:0] FWD_REGFILE = 2'd0;
  localparam logic [1:0] FWD_EX      = 2'd1;
  localparam logic [1:0] FWD_MEM     = 2'd2;
  localparam logic [1:0] FWD_WB      = 2'd3;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] addr;
    logic                  is_load;
  } trk_entry_t;

endpackage

// File: rtl/hazard_fwd_mux_sel.sv
// Maps the three per-stage operand matches to a forwarding select,
// youngest stage first so EX shadows MEM, which shadows WB.
module hazard_fwd_mux_sel
  import reg_hazard_ctrl_pkg::*;
(
  input  logic       match_ex,
  input  logic       match_mem,
  input  logic       match_wb,
  output logic [1:0] sel
);

  always_comb begin
    sel = FWD_REGFILE;
    if (match_ex)       sel = FWD_EX;
    else if (match_mem) sel = FWD_MEM;
    else if (match_wb)  sel = FWD_WB;
  end

endmodule

// File: rtl/reg_hazard_ctrl.sv
// Decode-stage hazard controller: tracks EX/MEM/WB destinations, drives
// per-operand forwarding selects, the load-use stall and a stall counter.
module reg_hazard_ctrl
  import reg_hazard_ctrl_pkg::*;
#(
  parameter int ADDR_W = REG_ADDR_W,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic              id_read_en_1,
  input  logic              id_read_en_2,
  input  logic [ADDR_W-1:0] id_addr_1,
  input  logic [ADDR_W-1:0] id_addr_2,
  input  logic              id_write_en,
  input  logic [ADDR_W-1:0] id_write_addr,
  input  logic              id_is_load,
  input  logic              ext_stall,
  input  logic              flush,
  output logic              stall_id,
  output logic [1:0]        fwd_sel_1,
  output logic [1:0]        fwd_sel_2,
  output logic [CNT_W-1:0]  stall_cnt
);

  trk_entry_t ex_q, mem_q, wb_q;
  trk_entry_t id_entry;

  logic rd_ok_1, rd_ok_2;
  logic m_ex_1, m_mem_1, m_wb_1;
  logic m_ex_2, m_mem_2, m_wb_2;

  // A read of $0 or a disabled read never matches anything in flight.
  assign rd_ok_1 = id_read_en_1 & (id_addr_1 != '0);
  assign rd_ok_2 = id_read_en_2 & (id_addr_2 != '0);

  assign m_ex_1  = rd_ok_1 & ex_q.valid  & (ex_q.addr  == id_addr_1);
  assign m_mem_1 = rd_ok_1 & mem_q.valid & (mem_q.addr == id_addr_1);
  assign m_wb_1  = rd_ok_1 & wb_q.valid  & (wb_q.addr  == id_addr_1);
  assign m_ex_2  = rd_ok_2 & ex_q.valid  & (ex_q.addr  == id_addr_2);
  assign m_mem_2 = rd_ok_2 & mem_q.valid & (mem_q.addr == id_addr_2);
  assign m_wb_2  = rd_ok_2 & wb_q.valid  & (wb_q.addr  == id_addr_2);

  // Only a load still in EX is unforwardable; flush kills the consumer anyway.
  assign stall_id = id_valid & ~flush & ex_q.is_load & (m_ex_1 | m_ex_2);

  always_comb begin
    id_entry         = '0;
    id_entry.valid   = id_valid & id_write_en & (id_write_addr != '0);
    id_entry.addr    = id_write_addr;
    id_entry.is_load = id_is_load;
  end

  hazard_fwd_mux_sel u_sel_1 (
    .match_ex  (m_ex_1),
    .match_mem (m_mem_1),
    .match_wb  (m_wb_1),
    .sel       (fwd_sel_1)
  );

  hazard_fwd_mux_sel u_sel_2 (
    .match_ex  (m_ex_2),
    .match_mem (m_mem_2),
    .match_wb  (m_wb_2),
    .sel       (fwd_sel_2)
  );

  // A memory freeze holds every stage, including any pending flush effect.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else if (!ext_stall) begin
      wb_q  <= mem_q;
      mem_q <= ex_q;
      if (stall_id || flush || !id_valid) ex_q <= '0;
      else                                ex_q <= id_entry;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (stall_id && !ext_stall && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_reg_hazard_ctrl.sv
// Bench for reg_hazard_ctrl: directed vector table, hand-written corner
// sequences, then random traffic against an age-ordered in-flight model.
module tb_reg_hazard_ctrl;

  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             id_valid, id_read_en_1, id_read_en_2;
  logic [4:0]       id_addr_1, id_addr_2, id_write_addr;
  logic             id_write_en, id_is_load, ext_stall, flush;
  logic             stall_id;
  logic [1:0]       fwd_sel_1, fwd_sel_2;
  logic [CNT_W-1:0] stall_cnt;

  reg_hazard_ctrl #(.ADDR_W(5), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .id_valid      (id_valid),
    .id_read_en_1  (id_read_en_1),
    .id_read_en_2  (id_read_en_2),
    .id_addr_1     (id_addr_1),
    .id_addr_2     (id_addr_2),
    .id_write_en   (id_write_en),
    .id_write_addr (id_write_addr),
    .id_is_load    (id_is_load),
    .ext_stall     (ext_stall),
    .flush         (flush),
    .stall_id      (stall_id),
    .fwd_sel_1     (fwd_sel_1),
    .fwd_sel_2     (fwd_sel_2),
    .stall_cnt     (stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       v, re1, re2, we, ld, xs, fl;
    logic [4:0] a1, a2, wa;
    logic       e_stall;
    logic [1:0] e_f1, e_f2;
    int         e_cnt;
  } vec_t;

  // In-flight model: index = age in cycles past ID (0 = EX, 1 = MEM, 2 = WB).
  typedef struct {
    logic       valid;
    logic [4:0] addr;
    logic       is_load;
  } mentry_t;

  mentry_t pipe [3];
  int      model_cnt;
  int      checks   = 0;
  int      failures = 0;
  vec_t    tbl [32];
  int      n_tbl;

  function automatic vec_t mk(input logic v, re1, input logic [4:0] a1,
                              input logic re2, input logic [4:0] a2,
                              input logic we, input logic [4:0] wa,
                              input logic ld, xs, fl, es,
                              input logic [1:0] e1, e2, input int ec);
    vec_t t;
    t.v = v; t.re1 = re1; t.a1 = a1; t.re2 = re2; t.a2 = a2;
    t.we = we; t.wa = wa; t.ld = ld; t.xs = xs; t.fl = fl;
    t.e_stall = es; t.e_f1 = e1; t.e_f2 = e2; t.e_cnt = ec;
    return t;
  endfunction

  function automatic logic [1:0] model_sel(input logic re, input logic [4:0] a);
    if (!re || a == 0) return 2'd0;
    for (int age = 0; age < 3; age++)
      if (pipe[age].valid && pipe[age].addr == a) return 2'(age + 1);
    return 2'd0;
  endfunction

  function automatic logic model_stall(input vec_t t);
    logic hit;
    hit = pipe[0].valid && pipe[0].is_load &&
          ((t.re1 && t.a1 != 0 && t.a1 == pipe[0].addr) ||
           (t.re2 && t.a2 != 0 && t.a2 == pipe[0].addr));
    return t.v && !t.fl && hit;
  endfunction

  function automatic vec_t predict(input vec_t t);
    vec_t r;
    r = t;
    r.e_stall = model_stall(t);
    r.e_f1    = model_sel(t.re1, t.a1);
    r.e_f2    = model_sel(t.re2, t.a2);
    r.e_cnt   = model_cnt;
    return r;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 3; i++) pipe[i] = '{1'b0, 5'd0, 1'b0};
    model_cnt = 0;
  endtask

  task automatic model_advance(input vec_t t);
    logic st;
    st = model_stall(t);
    if (!t.xs) begin
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      if (st || t.fl || !t.v) pipe[0] = '{1'b0, 5'd0, 1'b0};
      else pipe[0] = '{t.we && t.wa != 0, t.wa, t.ld};
      if (st && model_cnt < CNT_MAX) model_cnt++;
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t t);
    id_valid = t.v; id_read_en_1 = t.re1; id_addr_1 = t.a1;
    id_read_en_2 = t.re2; id_addr_2 = t.a2; id_write_en = t.we;
    id_write_addr = t.wa; id_is_load = t.ld; ext_stall = t.xs; flush = t.fl;
  endtask

  // Called just after a posedge; returns just after the following posedge.
  task automatic apply(input vec_t t, input string tag);
    drive(t);
    @(negedge clk);
    chk({tag, ".stall_id"}, int'(stall_id), int'(t.e_stall));
    if (!t.e_stall) begin
      chk({tag, ".fwd_sel_1"}, int'(fwd_sel_1), int'(t.e_f1));
      chk({tag, ".fwd_sel_2"}, int'(fwd_sel_2), int'(t.e_f2));
    end
    chk({tag, ".stall_cnt"}, int'(stall_cnt), t.e_cnt);
    model_advance(t);
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t t;
    rst = 1'b1;
    drive(mk(0,0,0,0,0,0,0,0,0,0, 0,0,0,0));
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    n_tbl = 0;
    //                v re1 a1 re2 a2 we wa ld xs fl  stall f1 f2 cnt
    tbl[n_tbl++] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0); // idle after reset
    tbl[n_tbl++] = mk(1, 1, 1, 0, 0, 1, 5, 0, 0, 0,  0, 0, 0, 0); // ADDIU $5
    tbl[n_tbl++] = mk(1, 1, 5, 1, 5, 1, 6, 0, 0, 0,  0, 1, 1, 0); // ADDU $6,$5,$5
    tbl[n_tbl++] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0);
    tbl[n_tbl++] = mk(1, 1, 5, 0, 0, 0, 0, 0, 0, 0,  0, 3, 0, 0); // $5 in WB
    tbl[n_tbl++] = mk(1, 1, 5, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0); // $5 retired
    tbl[n_tbl++] = mk(1, 1,29, 0, 0, 1, 8, 1, 0, 0,  0, 0, 0, 0); // LW $8
    tbl[n_tbl++] = mk(1, 1,29, 1, 8, 0, 0, 0, 0, 0,  1, 0, 0, 0); // SW rt=$8 stalls
    tbl[n_tbl++] = mk(1, 1,29, 1, 8, 0, 0, 0, 0, 0,  0, 0, 2, 1); // bubble in EX, MEM fwd
    tbl[n_tbl++] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1);
    tbl[n_tbl++] = mk(1, 1,29, 0, 0, 1, 9, 1, 0, 0,  0, 0, 0, 1); // LW $9
    tbl[n_tbl++] = mk(1, 1, 9, 0, 0, 1,10, 0, 1, 0,  1, 0, 0, 1); // freeze 1
    tbl[n_tbl++] = mk(1, 1, 9, 0, 0, 1,10, 0, 1, 0,  1, 0, 0, 1); // freeze 2
    tbl[n_tbl++] = mk(1, 1, 9, 0, 0, 1,10, 0, 1, 0,  1, 0, 0, 1); // freeze 3
    tbl[n_tbl++] = mk(1, 1, 9, 0, 0, 1,10, 0, 0, 0,  1, 0, 0, 1); // counted stall
    tbl[n_tbl++] = mk(1, 1, 9, 0, 0, 1,10, 0, 0, 0,  0, 2, 0, 2);
    tbl[n_tbl++] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 2);
    tbl[n_tbl++] = mk(1, 1, 1, 0, 0, 1, 0, 0, 0, 0,  0, 0, 0, 2); // ORI $0
    tbl[n_tbl++] = mk(1, 1, 0, 1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 2); // read $0
    tbl[n_tbl++] = mk(1, 1,29, 0, 0, 1, 0, 1, 0, 0,  0, 0, 0, 2); // LW $0
    tbl[n_tbl++] = mk(1, 1, 0, 1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 2); // read $0, no stall
    tbl[n_tbl++] = mk(1, 1,29, 0, 0, 1, 3, 1, 0, 0,  0, 0, 0, 2); // LW $3
    tbl[n_tbl++] = mk(1, 1, 3, 0, 0, 1, 4, 0, 0, 1,  0, 1, 0, 2); // flush beats stall
    tbl[n_tbl++] = mk(1, 1, 4, 1, 3, 0, 0, 0, 0, 0,  0, 0, 2, 2); // flushed $4 absent
    tbl[n_tbl++] = mk(1, 0, 0, 0, 0, 1, 7, 0, 0, 0,  0, 0, 0, 2); // ADDIU $7
    tbl[n_tbl++] = mk(1, 1, 7, 0, 0, 1, 7, 0, 0, 0,  0, 1, 0, 2); // ADDIU $7 again
    tbl[n_tbl++] = mk(1, 1, 7, 1, 7, 1,11, 0, 0, 0,  0, 1, 1, 2); // EX shadows MEM
    tbl[n_tbl++] = mk(1, 1, 7, 1, 7, 0, 0, 0, 0, 0,  0, 2, 2, 2); // MEM shadows WB
    tbl[n_tbl++] = mk(1, 1, 7, 0, 0, 0, 0, 0, 0, 0,  0, 3, 0, 2);
    tbl[n_tbl++] = mk(1, 0, 0, 0, 0, 1,12, 1, 0, 0,  0, 0, 0, 2); // LW $12
    tbl[n_tbl++] = mk(0, 1,12, 0, 0, 0, 0, 0, 0, 0,  0, 1, 0, 2); // no live ID, no stall
    tbl[n_tbl++] = mk(1, 1,12, 0, 0, 0, 0, 0, 0, 0,  0, 2, 0, 2);

    for (int i = 0; i < n_tbl; i++) apply(tbl[i], $sformatf("vec%0d", i));

    // Saturation: 17 load-use pairs, counter must stop at all-ones.
    for (int i = 0; i < 17; i++) begin
      apply(predict(mk(1, 0, 0, 0, 0, 1, 13, 1, 0, 0, 0, 0, 0, 0)), "sat_lw");
      t = predict(mk(1, 1, 13, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      chk("sat_expect_stall", int'(t.e_stall), 1);
      apply(t, "sat_use");
    end
    @(negedge clk);
    chk("sat_hold", int'(stall_cnt), CNT_MAX);
    @(posedge clk);
    #1;

    // Reset in the middle of a load-use stall drops stall_id at once.
    apply(predict(mk(1, 0, 0, 0, 0, 1, 14, 1, 0, 0, 0, 0, 0, 0)), "mid_lw");
    drive(mk(1, 1, 14, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    #2;
    chk("mid_stall_before", int'(stall_id), 1);
    rst = 1'b1;
    #1;
    chk("mid_stall_after_rst", int'(stall_id), 0);
    chk("mid_cnt_after_rst", int'(stall_cnt), 0);
    #1;
    rst = 1'b0;
    model_clear();
    @(posedge clk);
    #1;

    // Random traffic over a small register range to force collisions.
    for (int i = 0; i < 400; i++) begin
      t.v   = ($urandom_range(0, 9) != 0);
      t.re1 = $urandom_range(0, 1);
      t.a1  = 5'($urandom_range(0, 4));
      t.re2 = $urandom_range(0, 1);
      t.a2  = 5'($urandom_range(0, 4));
      t.we  = ($urandom_range(0, 3) != 0);
      t.wa  = 5'($urandom_range(0, 4));
      t.ld  = ($urandom_range(0, 2) == 0);
      t.xs  = ($urandom_range(0, 7) == 0);
      t.fl  = ($urandom_range(0, 9) == 0);
      apply(predict(t), "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
